// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-byte prefetch queue. It issues one byte fetch per cycle to an
//   instruction memory with one cycle of read latency. Returned bytes are
//   buffered, together with the address they came from, in a small circular
//   FIFO. A new fetch is only issued when the queued entries plus the
//   outstanding fetch leave room for it, so the FIFO can never overflow.
//
// Parameters
//   DEPTH          number of buffered entries (power of two, 2..16)
//   RESET_PC       fetch address loaded while rst is high
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset, highest priority
//   addr_i         instruction memory address (the fetch_pc register)
//   din_i          instruction memory data, valid one cycle after addr_i
//   hold           suppresses new fetches while high
//   redirect       flush the queue and restart fetching at redirect_addr
//   redirect_addr  new fetch address, sampled when redirect is high
//   instr          head-entry byte
//   instr_pc       address the head byte was fetched from
//   instr_valid    head entry present (forced low during a redirect)
//   instr_ready    consumer accepts the head byte when instr_valid is high
//   level          number of queued entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [15:0]              addr_i,
    input  logic [7:0]               din_i,
    input  logic                     hold,
    input  logic                     redirect,
    input  logic [15:0]              redirect_addr,
    output logic [7:0]               instr,
    output logic [15:0]              instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    // Architectural state
    logic [15:0]      fetch_pc_r;
    logic             inflight_r;
    logic [15:0]      inflight_pc_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] level_r;

    // Entry storage (data byte and its fetch address)
    logic [7:0]       data_mem_r [DEPTH];
    logic [15:0]      pc_mem_r   [DEPTH];

    // Control decisions for this cycle
    logic [CNT_W-1:0] occupancy_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    logic             valid_s;

    // The outstanding fetch already owns a slot, so count it as occupied.
    // A pop in the same cycle deliberately gives no credit.
    assign occupancy_s = level_r + CNT_W'(inflight_r);
    assign issue_s     = (occupancy_s < DEPTH_C) & ~hold & ~redirect & ~rst;

    // A response landing in a redirect cycle belongs to the old stream.
    assign push_s      = inflight_r & ~redirect & ~rst;
    assign valid_s     = (level_r != CNT_ZERO) & ~redirect;
    assign pop_s       = valid_s & instr_ready & ~rst;

    assign addr_i      = fetch_pc_r;
    assign instr_valid = valid_s;
    assign instr       = data_mem_r[head_r];
    assign instr_pc    = pc_mem_r[head_r];
    assign level       = level_r;

    // Fetch address, outstanding-fetch tracking, pointers and level.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 16'h0000;
            head_r        <= PTR_ZERO;
            tail_r        <= PTR_ZERO;
            level_r       <= CNT_ZERO;
        end else if (redirect) begin
            // Flush: empty the FIFO by collapsing head onto tail.
            fetch_pc_r    <= redirect_addr;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
            head_r        <= tail_r;
            tail_r        <= tail_r;
            level_r       <= CNT_ZERO;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= fetch_pc_r;
                fetch_pc_r    <= fetch_pc_r + 16'h0001;
            end else begin
                inflight_pc_r <= inflight_pc_r;
                fetch_pc_r    <= fetch_pc_r;
            end

            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end

            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end

            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + CNT_ONE;
                2'b01:   level_r <= level_r - CNT_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Entry storage write port; contents need no reset because level gates them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[tail_r] <= din_i;
            pc_mem_r[tail_r]   <= inflight_pc_r;
        end else begin
            data_mem_r[tail_r] <= data_mem_r[tail_r];
            pc_mem_r[tail_r]   <= pc_mem_r[tail_r];
        end
    end

    fetch_queue_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .level (level_r)
    );

endmodule

// -----------------------------------------------------------------------------
// fetch_queue_chk
//   Property checker for fetch_queue: the issue rule must make a push into a
//   full FIFO (and a pop from an empty one) impossible.
//
// Ports
//   clk, rst       clock and synchronous reset of the checked block
//   push, pop      FIFO write / read strobes
//   level          FIFO occupancy
// -----------------------------------------------------------------------------
module fetch_queue_chk #(
    parameter int DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    input logic                     push,
    input logic                     pop,
    input logic [$clog2(DEPTH):0]   level
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // No write may land on a full FIFO unless a read frees a slot the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (level == DEPTH_C)));

    // No read may happen on an empty FIFO.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (level == CNT_ZERO)));

    // Occupancy never exceeds the storage size.
    a_level_bound: assert property (@(posedge clk) disable iff (rst)
        (level <= DEPTH_C));

endmodule
